// File: rtl/vctcxo_dac_sched_if.sv
// Request bundle for the VCTCXO trim-DAC scheduler: one valid/ready/value
// channel for the PLL discipline loop and one for the user override path.
interface vctcxo_dac_sched_if;
  logic        loop_valid;
  logic        loop_ready;
  logic [15:0] loop_value;
  logic        user_valid;
  logic        user_ready;
  logic [15:0] user_value;

  modport master (
    output loop_valid, loop_value, user_valid, user_value,
    input  loop_ready, user_ready
  );

  modport slave (
    input  loop_valid, loop_value, user_valid, user_value,
    output loop_ready, user_ready
  );
endinterface

// File: rtl/vctcxo_dac_sched.sv
// Trim-DAC write scheduler: picks the owner by mode, forces init/owner-switch
// frames, and shifts each 24-bit word out MSB first on sync_n/sclk/mosi.
module vctcxo_dac_sched #(
  parameter int          SCLK_DIV    = 4,
  parameter logic [3:0]  CMD         = 4'b0011,
  parameter logic [15:0] DAC_DEFAULT = 16'd42580
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  vctcxo_dac_sched_if.slave        req,
  output logic                     busy,
  output logic                     frame_done,
  output logic [15:0]              dac_value,
  output logic                     sync_n,
  output logic                     sclk,
  output logic                     mosi
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  localparam int             CW        = $clog2(2 * SCLK_DIV + 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'(2 * SCLK_DIV - 1);
  localparam logic [5:0]     HALF_END  = 6'd48;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_half;
  logic [23:0]   r_shift;
  logic [15:0]   r_value;
  logic [15:0]   r_dac_value;
  logic [15:0]   r_loop_shadow;
  logic [15:0]   r_user_shadow;
  logic          r_sync_n;
  logic          r_sclk;
  logic          r_mosi;
  logic          r_frame_done;
  logic          r_mode_q;
  logic          r_init_pend;
  logic          r_switch_pend;

  logic          w_idle;
  logic          w_mode_chg;
  logic          w_force;
  logic          w_owner_ready;
  logic          w_loop_hs;
  logic          w_user_hs;
  logic          w_owner_hs;
  logic          w_launch;
  logic          w_switch_launch;
  logic [15:0]   w_launch_val;
  logic [23:0]   w_word;
  logic          w_half_end;
  logic          w_gap_end;

  // Owner/force decode; the owner's ready is combinational so the handshake
  // and the frame launch share the same IDLE cycle.
  always_comb begin
    w_idle          = (r_state == S_IDLE);
    w_mode_chg      = (mode != r_mode_q);
    w_force         = r_init_pend | r_switch_pend | w_mode_chg;
    w_owner_ready   = w_idle & ~w_force;
    w_loop_hs       = req.loop_valid & req.loop_ready;
    w_user_hs       = req.user_valid & req.user_ready;
    w_owner_hs      = mode ? w_user_hs : w_loop_hs;
    w_launch        = w_idle & (w_force | w_owner_hs);
    w_switch_launch = w_idle & ~r_init_pend & (r_switch_pend | w_mode_chg);
    if (r_init_pend)
      w_launch_val = DAC_DEFAULT;
    else if (r_switch_pend | w_mode_chg)
      w_launch_val = mode ? r_user_shadow : r_loop_shadow;
    else
      w_launch_val = mode ? req.user_value : req.loop_value;
    w_word     = {CMD, 4'b0000, w_launch_val};
    w_half_end = (r_cnt == HALF_LAST);
    w_gap_end  = (r_cnt == GAP_LAST);
  end

  assign req.loop_ready = mode ? 1'b1 : w_owner_ready;
  assign req.user_ready = mode ? w_owner_ready : 1'b1;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_half_end && r_half == HALF_END) w_state_nxt = S_GAP;
      S_GAP:   if (w_gap_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_half        <= '0;
      r_shift       <= '0;
      r_value       <= '0;
      r_dac_value   <= '0;
      r_loop_shadow <= DAC_DEFAULT;
      r_user_shadow <= DAC_DEFAULT;
      r_sync_n      <= 1'b1;
      r_sclk        <= 1'b0;
      r_mosi        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_mode_q      <= mode;
      r_init_pend   <= 1'b1;
      r_switch_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode_q     <= mode;
      r_frame_done <= 1'b0;
      if (w_loop_hs) r_loop_shadow <= req.loop_value;
      if (w_user_hs) r_user_shadow <= req.user_value;
      if (w_switch_launch)  r_switch_pend <= 1'b0;
      else if (w_mode_chg)  r_switch_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_init_pend <= 1'b0;
            r_value     <= w_launch_val;
            r_shift     <= w_word;
            r_mosi      <= w_word[23];
            r_sync_n    <= 1'b0;
            r_sclk      <= 1'b0;
            r_cnt       <= '0;
            r_half      <= '0;
          end
        end
        S_SHIFT: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (r_half == HALF_END) begin
              r_sync_n     <= 1'b1;
              r_sclk       <= 1'b0;
              r_mosi       <= 1'b0;
              r_frame_done <= 1'b1;
              r_dac_value  <= r_value;
            end else begin
              r_half <= r_half + 6'd1;
              r_sclk <= ~r_sclk;
              // Falling edge: advance to the next bit while sclk is low.
              if (r_sclk) begin
                r_shift <= {r_shift[22:0], 1'b0};
                r_mosi  <= r_shift[22];
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP:   r_cnt <= w_gap_end ? '0 : r_cnt + CW'(1);
        default: r_cnt <= '0;
      endcase
    end
  end

  assign busy       = ~w_idle;
  assign frame_done = r_frame_done;
  assign dac_value  = r_dac_value;
  assign sync_n     = r_sync_n;
  assign sclk       = r_sclk;
  assign mosi       = r_mosi;

endmodule

// File: tb/tb_vctcxo_dac_sched.sv
// Directed bench for vctcxo_dac_sched: DUT a at SCLK_DIV=4, DUT b at SCLK_DIV=1,
// with an SPI monitor reconstructing each shifted word and its timing.
module tb_vctcxo_dac_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, mode_a, mode_b;
  logic        a_busy, a_fd, a_sync_n, a_sclk, a_mosi;
  logic        b_busy, b_fd, b_sync_n, b_sclk, b_mosi;
  logic [15:0] a_dac, b_dac;

  vctcxo_dac_sched_if ifa ();
  vctcxo_dac_sched_if ifb ();

  vctcxo_dac_sched #(.SCLK_DIV(4)) dut_a (
    .clk(clk), .reset(rst_a), .mode(mode_a), .req(ifa),
    .busy(a_busy), .frame_done(a_fd), .dac_value(a_dac),
    .sync_n(a_sync_n), .sclk(a_sclk), .mosi(a_mosi)
  );

  vctcxo_dac_sched #(.SCLK_DIV(1)) dut_b (
    .clk(clk), .reset(rst_b), .mode(mode_b), .req(ifb),
    .busy(b_busy), .frame_done(b_fd), .dac_value(b_dac),
    .sync_n(b_sync_n), .sclk(b_sclk), .mosi(b_mosi)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI monitor, index 0 = dut_a, 1 = dut_b
  logic [1:0] w_sync, w_sclk, w_mosi, w_busy, w_fd;
  assign w_sync = {b_sync_n, a_sync_n};
  assign w_sclk = {b_sclk, a_sclk};
  assign w_mosi = {b_mosi, a_mosi};
  assign w_busy = {b_busy, a_busy};
  assign w_fd   = {b_fd, a_fd};

  logic [1:0]  p_sync = 2'b11, p_sclk = 2'b00, p_mosi = 2'b00, p_busy = 2'b00;
  logic [23:0] word[2], last_word[2];
  int rises[2], last_rises[2], frames[2], viol[2], stray[2];
  int fall_cyc[2], rise_cyc[2], fd_cyc[2], idle_cyc[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      word[i] = '0; last_word[i] = '0; rises[i] = 0; last_rises[i] = 0;
      frames[i] = 0; viol[i] = 0; stray[i] = 0;
      fall_cyc[i] = 0; rise_cyc[i] = 0; fd_cyc[i] = 0; idle_cyc[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!w_sync[i] && p_sync[i]) begin
        fall_cyc[i] = cyc; rises[i] = 0; word[i] = '0;
      end
      if (w_sclk[i] && !p_sclk[i]) begin
        if (w_sync[i]) stray[i]++;
        else begin
          rises[i]++;
          word[i] = {word[i][22:0], w_mosi[i]};
        end
      end
      if (w_sclk[i] && (w_mosi[i] != p_mosi[i])) viol[i]++;
      if (w_sync[i] && !p_sync[i]) begin
        rise_cyc[i] = cyc; last_word[i] = word[i]; last_rises[i] = rises[i]; frames[i]++;
      end
      if (w_fd[i]) fd_cyc[i] = cyc;
      if (!w_busy[i] && p_busy[i]) idle_cyc[i] = cyc;
    end
    p_sync = w_sync; p_sclk = w_sclk; p_mosi = w_mosi; p_busy = w_busy;
  end

  task automatic wait_done(input int idx, input string tag);
    bit ok = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      if (w_fd[idx]) begin ok = 1; break; end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int idx, input string tag);
    bit ok = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk); #1;
      if (!w_busy[idx]) begin ok = 1; break; end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int  h1, h2, bad, busy_seen;
  int  frames0;
  bit  got;

  initial begin
    rst_a = 1; rst_b = 1; mode_a = 0; mode_b = 0;
    ifa.loop_valid = 0; ifa.loop_value = '0; ifa.user_valid = 0; ifa.user_value = '0;
    ifb.loop_valid = 0; ifb.loop_value = '0; ifb.user_valid = 0; ifb.user_value = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_sync_n", a_sync_n, 1);
    check("rst_sclk",   a_sclk,   0);
    check("rst_mosi",   a_mosi,   0);
    check("rst_busy",   a_busy,   0);
    check("rst_fd",     a_fd,     0);
    check("rst_dac",    a_dac,    0);
    check("rst_b_sync_n", b_sync_n, 1);

    // Init frame after reset release
    rst_a = 0;
    wait_done(0, "t1_done");
    check("t1_word",   last_word[0], 32'h30A654);
    check("t1_rises",  last_rises[0], 24);
    check("t1_low",    rise_cyc[0] - fall_cyc[0], 196);
    check("t1_fd_at",  fd_cyc[0] - (fall_cyc[0] - 1), 197);
    check("t1_dac",    a_dac, 16'hA654);
    wait_idle(0, "t1_idle");
    check("t1_idle_at", idle_cyc[0] - fall_cyc[0], 204);

    // Owner loop writes, valid held
    @(negedge clk);
    ifa.loop_value = 16'h1234; ifa.loop_valid = 1;
    #1;
    check("t2_ready_idle", ifa.loop_ready, 1);
    h1 = cyc; bad = 0; busy_seen = 0; got = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (a_busy) busy_seen++;
      if (a_busy && ifa.loop_ready) bad++;
      if (ifa.loop_ready) begin got = 1; break; end
    end
    h2 = cyc;
    check("t2_second_hs", got, 1);
    check("t2_hs_gap",    h2 - h1, 205);
    check("t2_busy_cyc",  busy_seen, 204);
    check("t2_ready_busy", bad, 0);
    check("t2_word",      last_word[0], 32'h301234);
    check("t2_dac",       a_dac, 16'h1234);
    @(negedge clk);
    ifa.loop_valid = 0;

    // Non-owner user writes during a busy loop frame, then switch to user
    frames0 = frames[0];
    @(negedge clk);
    ifa.user_value = 16'hBEEF; ifa.user_valid = 1;
    #1;
    check("t3_ready1", ifa.user_ready, 1);
    check("t3_busy",   a_busy, 1);
    @(negedge clk);
    ifa.user_value = 16'h0F0F;
    #1;
    check("t3_ready2", ifa.user_ready, 1);
    @(negedge clk);
    ifa.user_valid = 0; mode_a = 1;
    wait_done(0, "t3_loop_done");
    check("t3_loop_word", last_word[0], 32'h301234);
    wait_done(0, "t3_sw_done");
    check("t3_sw_word",  last_word[0], 32'h300F0F);
    check("t3_sw_dac",   a_dac, 16'h0F0F);
    check("t3_frames",   frames[0] - frames0, 2);

    // Switch back to loop, then toggle to user together with a user request
    wait_idle(0, "t4_idle0");
    @(negedge clk);
    mode_a = 0;
    wait_done(0, "t4_back_done");
    check("t4_back_word", last_word[0], 32'h301234);
    wait_idle(0, "t4_idle1");
    @(negedge clk);
    mode_a = 1; ifa.user_value = 16'h5555; ifa.user_valid = 1;
    #1;
    check("t4_ready_force", ifa.user_ready, 0);
    check("t4_loop_nonown", ifa.loop_ready, 1);
    got = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (ifa.user_ready) begin got = 1; break; end
    end
    check("t4_hs_seen", got, 1);
    check("t4_hs_at",   cyc - fall_cyc[0], 204);
    check("t4_sw_word", last_word[0], 32'h300F0F);
    @(negedge clk);
    ifa.user_valid = 0;
    wait_done(0, "t4_user_done");
    check("t4_user_word", last_word[0], 32'h305555);
    check("t4_user_dac",  a_dac, 16'h5555);

    // Reset during bit 10 aborts the frame
    wait_idle(0, "t5_idle");
    @(negedge clk);
    ifa.user_value = 16'h1111; ifa.user_valid = 1;
    @(negedge clk);
    ifa.user_valid = 0;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (rises[0] == 14 && a_sclk) begin got = 1; break; end
    end
    check("t5_bit10_seen", got, 1);
    rst_a = 1;
    @(negedge clk);
    rst_a = 0;
    #1;
    check("t5_sync_n", a_sync_n, 1);
    check("t5_sclk",   a_sclk, 0);
    check("t5_dac",    a_dac, 0);
    check("t5_rises",  last_rises[0], 14);
    wait_done(0, "t5_init_done");
    check("t5_init_word",  last_word[0], 32'h30A654);
    check("t5_init_rises", last_rises[0], 24);

    // SCLK_DIV = 1
    @(negedge clk);
    rst_b = 0;
    wait_done(1, "t6_done");
    check("t6_word",  last_word[1], 32'h30A654);
    check("t6_rises", last_rises[1], 24);
    check("t6_low",   rise_cyc[1] - fall_cyc[1], 49);
    wait_idle(1, "t6_idle");
    check("t6_idle_at", idle_cyc[1] - fall_cyc[1], 51);
    @(negedge clk);
    ifb.loop_value = 16'hC3A5; ifb.loop_valid = 1;
    #1;
    check("t6_ready", ifb.loop_ready, 1);
    h1 = cyc; got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (ifb.loop_ready) begin got = 1; break; end
    end
    check("t6_hs_gap", cyc - h1, 52);
    @(negedge clk);
    ifb.loop_valid = 0;
    check("t6_c3_word", last_word[1], 32'h30C3A5);
    check("t6_c3_low",  rise_cyc[1] - fall_cyc[1], 49);
    wait_done(1, "t6_c3b_done");

    check("mosi_stable_a", viol[0], 0);
    check("mosi_stable_b", viol[1], 0);
    check("stray_rise_a",  stray[0], 0);
    check("stray_rise_b",  stray[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
